// File: rtl/flag_beacon.sv
// Serial flag transmitter: a debounced-edge press with the right key sends FLAG
// as REPEAT UART-like frames (start, 16 data bits LSB first, stop) on o_tx.
module flag_beacon #(
    parameter logic [15:0] KEY        = 16'hD68D,
    parameter logic [15:0] FLAG       = 16'h2C5A,
    parameter int          BIT_CYCLES = 100,
    parameter int          REPEAT     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_key_switch,
    input  logic        i_show_button,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_reject
);

    localparam int            TW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(BIT_CYCLES - 1);
    localparam logic [4:0]    REPEAT_N  = 5'(REPEAT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         r_state;
    logic           r_s1;
    logic           r_s2;
    logic           r_s3;
    logic [15:0]    r_shift;
    logic [TW-1:0]  r_bit_timer;
    logic [3:0]     r_bit_idx;
    logic [3:0]     r_frame_cnt;
    logic           r_tx;
    logic           r_busy;
    logic           r_done;
    logic           r_reject;

    logic           w_press;
    logic           w_key_ok;
    logic           w_bit_end;
    logic [4:0]     w_frames_sent;

    // s3 clears in reset, so a button held through reset still yields one event.
    assign w_press       = r_s2 & ~r_s3;
    assign w_key_ok      = (i_key_switch == KEY);
    assign w_bit_end     = (r_bit_timer == LAST_TICK);
    assign w_frames_sent = {1'b0, r_frame_cnt} + 5'd1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_show_button;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bit_timer <= '0;
            r_bit_idx   <= '0;
            r_frame_cnt <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reject    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx        <= 1'b1;
                    r_busy      <= 1'b0;
                    r_bit_timer <= '0;
                    if (w_press) begin
                        if (w_key_ok) begin
                            r_shift     <= FLAG;
                            r_frame_cnt <= '0;
                            r_bit_idx   <= '0;
                            r_state     <= START;
                            r_tx        <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_bit_timer <= '0;
                        r_bit_idx   <= '0;
                        r_state     <= DATA;
                        r_tx        <= r_shift[0];
                    end else begin
                        r_bit_timer <= r_bit_timer + TW'(1);
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        r_bit_timer <= '0;
                        r_shift     <= r_shift >> 1;
                        // o_tx is registered, so present the next bit alongside the shift.
                        if (r_bit_idx == 4'd15) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer + TW'(1);
                    end
                end

                STOP: begin
                    if (w_bit_end) begin
                        r_bit_timer <= '0;
                        r_frame_cnt <= r_frame_cnt + 4'd1;
                        if (w_frames_sent < REPEAT_N) begin
                            r_shift <= FLAG;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_timer <= r_bit_timer + TW'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx     = r_tx;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_reject = r_reject;

endmodule

// File: doc/flag_beacon.md
# flag_beacon

Serial flag transmitter for the debugging challenge board. When the operator presses `show_button` with the correct 16-bit key on `key_switch`, the block sends a parameterised 16-bit flag on a single output pin `tx`. The pin drives an LED or header, and the player decodes it with the ILA or a scope. Each frame is UART-like, LSB first, and the frame is repeated a fixed number of times. A wrong key produces a one-cycle reject pulse and no transmission.

## Interface
- `KEY`, 16'hD68D, key that `key_switch` must equal for the flag to be sent.
- `FLAG`, 16'h2C5A, payload transmitted.
- `BIT_CYCLES`, 100, clock cycles per bit; legal range is ≥2. The counter width is $clog2(BIT_CYCLES).
- `REPEAT`, 2, number of back-to-back frames per accepted press; legal range is 1..15.

- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `key_switch`  in  16  slide-switch key; treated as static and not synchronised.
- `show_button`  in  1  asynchronous push button; passes through a 2-flop synchroniser inside the block.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while frames are being sent.
- `done`  out  1  one-cycle pulse when the last frame completes.
- `reject`  out  1  one-cycle pulse when a press is made with the wrong key.

## Operation
- Synchroniser: `s1 <= show_button`, then `s2 <= s1`, then `s3 <= s2`. A press event is `s2 & ~s3`. Only rising edges count, so holding the button produces exactly one event.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1, `busy`=0.
  - On a press event, compare `key_switch` to `KEY` in that same cycle.
  - Match: latch `FLAG` into the shift register, set frame_cnt=0, go to START.
  - Mismatch: pulse `reject`, stay in IDLE.
- START: `tx`=0 for BIT_CYCLES cycles, then go to DATA with bit_idx=0.
- DATA:
  - `tx`=shift[0] for BIT_CYCLES cycles.
  - Then shift right. If bit_idx=15 go to STOP, otherwise increment bit_idx.
- STOP:
  - `tx`=1 for BIT_CYCLES cycles.
  - Then increment frame_cnt.
  - If frame_cnt+1 < REPEAT, reload `FLAG` and go to START.
  - Otherwise pulse `done` and go to IDLE.
- `busy` is 1 in START, DATA and STOP.
- Press events while `busy` is high are ignored: no reject and no restart.
- `key_switch` is sampled only at the accepting press event. Changing it mid-transmission has no effect.
- Reset (`rst_n`=0 at a clock edge), from any state including mid-frame:
  - state becomes IDLE.
  - `tx`=1, `busy`=0, `done`=0, `reject`=0.
  - s1, s2 and s3 are cleared to 0, and all counters are cleared to 0.
  - A button already held high through reset produces one press event after reset is released, because s3 starts at 0.
- All outputs are registered. `tx` is never combinationally derived from inputs.

## Timing
- Let E0 be the first clock edge that samples `show_button`=1.
  - s2=1 after E1.
  - The press event is evaluated in the cycle between E1 and E2.
  - The state and `tx`=0 (or the `reject` pulse) become visible after E2.
- Latency from press to start bit is therefore 2 edges after E0.
- Each bit lasts exactly BIT_CYCLES cycles, counted by a bit timer that runs 0..BIT_CYCLES-1.
- One frame is 18×BIT_CYCLES cycles: 1 start bit, 16 data bits, 1 stop bit.
- `busy` stays high for exactly REPEAT×18×BIT_CYCLES cycles.
- `done` is high in the first cycle after the final stop bit, which is the same cycle in which `busy` returns to 0. `done` never overlaps `busy`.
- A press accepted in the same cycle that `done` pulses is impossible, because the event was ignored during busy.
- The next press can be accepted from the following IDLE cycle onward.
- `reject` lasts one cycle. Consecutive wrong presses each produce one pulse, provided `show_button` is released between them.

## Test plan
Use BIT_CYCLES=4, REPEAT=2, KEY=16'hD68D, FLAG=16'h2C5A for all scenarios.

- Reset: hold `rst_n`=0 for 3 cycles with random inputs. Expect `tx`=1, `busy`=0, `done`=0, `reject`=0 throughout and after release.
- Correct key: key_switch=16'hD68D, pulse button for 5 cycles.
  - `tx` falls 2 edges after E0.
  - The bit sequence is 0, then 0,1,0,1,1,0,1,0,0,0,1,1,0,1,0,0 (LSB first), then 1, each bit held for 4 cycles, sent twice.
  - `busy` is high for 144 cycles, then `done` pulses once.
- Wrong key: key_switch=16'hD68C, press. Expect one `reject` pulse 2 edges after E0, `tx` stays 1, `busy` stays 0.
- Press during busy / key change: after an accepted press, re-press at cycle 30 and change key_switch to 16'h0000. Expect a waveform identical to the correct-key scenario and no `reject`.
- Held button: hold `show_button`=1 for 300 cycles with the correct key. Expect exactly one 144-cycle transmission and one `done`.
- Reset mid-frame: assert `rst_n`=0 at cycle 40 of a transmission.
  - On the next edge `tx`=1 and `busy`=0.
  - Then release reset and press again: the full transmission restarts from the start bit.
